biriscv_ram_ctrl: RTL

Initiator for the single-port word RAM interface (req/we/word-addr/wdata/wstrb in, rdata out one cycle later). It sits between the core LSU and the RAM.
- Accepts byte-addressed load/store requests of byte, half or word size on a valid/ready handshake.
- Drives aligned word accesses with byte strobes.
- Returns load data aligned, and sign- or zero-extended, on a valid/ready response channel.
- Sustains one access per cycle.

---
 rtl/biriscv_ram_pkg.sv | 20 ++
 rtl/biriscv_ram_lane.sv | 61 ++++++
 rtl/biriscv_ram_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/biriscv_ram_pkg.sv
// rtl/biriscv_ram_pkg.sv - shared types and constants for the biriscv RAM controller
// Contents: mem_size_e (access size encoding), ctrl_state_e (controller FSM states),
//           BYTES_PER_WORD (byte lanes per RAM word).
package biriscv_ram_pkg;

  typedef enum logic [1:0] {
    SIZE_B    = 2'b00,
    SIZE_H    = 2'b01,
    SIZE_W    = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } ctrl_state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/biriscv_ram_lane.sv
// rtl/biriscv_ram_lane.sv - byte-lane steering for stores and lane extraction/extension for loads
// Ports:
//   st_off, st_size, st_data  : store byte offset, size and right-justified data
//   st_strb, st_lane_data     : byte strobes and data replicated onto the addressed lanes
//   ld_off, ld_size, ld_unsigned, ld_word : captured load offset/size/extension and RAM word
//   ld_data                   : aligned, extended load result
// Purely combinational.
module biriscv_ram_lane
  import biriscv_ram_pkg::*;
(
  input  logic [1:0]                st_off,
  input  mem_size_e                 st_size,
  input  logic [31:0]               st_data,
  output logic [BYTES_PER_WORD-1:0] st_strb,
  output logic [31:0]               st_lane_data,
  input  logic [1:0]                ld_off,
  input  mem_size_e                 ld_size,
  input  logic                      ld_unsigned,
  input  logic [31:0]               ld_word,
  output logic [31:0]               ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Replicating the data across lanes means the strobes alone pick the target bytes.
  // A misaligned half/word simply ignores the low offset bits here.
  always_comb begin
    st_strb      = '0;
    st_lane_data = st_data;
    case (st_size)
      SIZE_B: begin
        st_strb      = 4'b0001 << st_off;
        st_lane_data = {4{st_data[7:0]}};
      end
      SIZE_H: begin
        st_strb      = 4'b0011 << {st_off[1], 1'b0};
        st_lane_data = {2{st_data[15:0]}};
      end
      SIZE_W: begin
        st_strb      = 4'b1111;
        st_lane_data = st_data;
      end
      default: begin
        st_strb      = '0;
        st_lane_data = st_data;
      end
    endcase
  end

  always_comb begin
    ld_byte = 8'(ld_word >> {ld_off, 3'b000});
    ld_half = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
    case (ld_size)
      SIZE_B:  ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SIZE_H:  ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/biriscv_ram_ctrl.sv
// rtl/biriscv_ram_ctrl.sv - LSU-side initiator for a single-port word RAM (one access per cycle)
// Ports:
//   clk_i, rst_i                          : clock, asynchronous active-high reset
//   cpu_valid_i/cpu_ready_o               : request handshake
//   cpu_we_i, cpu_addr_i, cpu_size_i,
//   cpu_unsigned_i, cpu_wdata_i           : request attributes (byte address, right-justified data)
//   rsp_valid_o/rsp_ready_i               : response handshake
//   rsp_rdata_o, rsp_err_o                : load result (0 for stores/faults), fault flag
//   ram_req_o, ram_we_o, ram_addr_o,
//   ram_wdata_o, ram_wstrb_o, ram_rdata_i : word RAM port, read data one cycle after ram_req_o
// Build option: BIRISCV_RAM_CTRL_MISALIGN_ERR_EN - misaligned half/word accesses fault
//   instead of being silently aligned down.
module biriscv_ram_ctrl
  import biriscv_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 20,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    cpu_valid_i,
  output logic                    cpu_ready_o,
  input  logic                    cpu_we_i,
  input  logic [ADDR_WIDTH+1:0]   cpu_addr_i,
  input  logic [1:0]              cpu_size_i,
  input  logic                    cpu_unsigned_i,
  input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    ram_req_o,
  output logic                    ram_we_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  output logic [3:0]              ram_wstrb_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("biriscv_ram_ctrl: DATA_WIDTH must be 32");
    end
  endgenerate

  ctrl_state_e state, state_nxt;
  logic        cap_we, cap_unsigned, cap_fault;
  logic [1:0]  cap_off;
  mem_size_e   cap_size;

  mem_size_e   req_size;
  logic        req_fault;
  logic        accept;
  logic [3:0]  lane_strb;
  logic [31:0] lane_wdata;
  logic [31:0] load_data;

  assign req_size = mem_size_e'(cpu_size_i);

  always_comb begin
    req_fault = (req_size == SIZE_RSVD);
`ifdef BIRISCV_RAM_CTRL_MISALIGN_ERR_EN
    if ((req_size == SIZE_H) && cpu_addr_i[0])
      req_fault = 1'b1;
    if ((req_size == SIZE_W) && (cpu_addr_i[1:0] != 2'b00))
      req_fault = 1'b1;
`endif
  end

  biriscv_ram_lane u_lane (
    .st_off       (cpu_addr_i[1:0]),
    .st_size      (req_size),
    .st_data      (cpu_wdata_i),
    .st_strb      (lane_strb),
    .st_lane_data (lane_wdata),
    .ld_off       (cap_off),
    .ld_size      (cap_size),
    .ld_unsigned  (cap_unsigned),
    .ld_word      (ram_rdata_i),
    .ld_data      (load_data)
  );

  // State register plus the attributes of the accepted request, which shape its response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cap_off      <= 2'b00;
      cap_size     <= SIZE_B;
      cap_unsigned <= 1'b0;
      cap_we       <= 1'b0;
      cap_fault    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_off      <= cpu_addr_i[1:0];
        cap_size     <= req_size;
        cap_unsigned <= cpu_unsigned_i;
        cap_we       <= cpu_we_i;
        cap_fault    <= req_fault;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RESP : IDLE;
      RESP: begin
        if (rsp_ready_i)
          state_nxt = accept ? RESP : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The response slot frees up in the same cycle it is consumed, so a new request can
  // be accepted alongside the handshake. Reset forces ready low since state alone reads IDLE.
  always_comb begin
    rsp_valid_o = (state == RESP);
    cpu_ready_o = ~rst_i & ((state == IDLE) | (rsp_valid_o & rsp_ready_i));
    accept      = cpu_valid_i & cpu_ready_o;
    ram_req_o   = accept & ~req_fault;
    ram_we_o    = ram_req_o & cpu_we_i;
    ram_addr_o  = cpu_addr_i[ADDR_WIDTH+1:2];
    ram_wdata_o = lane_wdata;
    ram_wstrb_o = ram_we_o ? lane_strb : 4'b0000;
    rsp_err_o   = rsp_valid_o & cap_fault;
    rsp_rdata_o = (rsp_valid_o & ~cap_we & ~cap_fault) ? load_data : '0;
  end

endmodule
